instr_imm_encoder: RTL and testbench

Packs a sign-extended 32-bit immediate into the format-specific bit positions of a RISC-V instruction word: I, S, B, U or J. It is the inverse of the core's immediate extraction. It also expands a load-immediate pseudo-op into one or two real instructions. It sits between the boot/self-test instruction sequencer and instruction memory write port, with valid/ready on both sides and a one-entry registered output.

---
 rtl/instr_imm_encoder.sv | 136 +++++++++++++
 tb/tb_instr_imm_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_imm_encoder.sv
// Packs a sign-extended immediate into RISC-V I/S/B/U/J instruction fields.
// It also expands the LI pseudo-op into ADDI, or LUI followed by an optional ADDI, behind a one-entry output register.
module instr_imm_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_fmt_i,
  input  logic [31:0] req_base_i,
  input  logic [31:0] req_imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic        out_err_o
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic {IDLE, LI_LO} state_t;

  state_t      state, state_next;
  logic [31:0] pending;
  logic        accept;
  logic [31:0] enc_instr, enc_pending;
  logic        enc_err, enc_two;
  logic        fits_12, fits_13, fits_21;
  logic [31:0] li_sum;
  logic [4:0]  rd;

  assign req_ready_o = (state == IDLE) && (!out_valid_o || out_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  // Signed range tests: every bit above the top field bit must equal it.
  assign fits_12 = (req_imm_i[31:11] == {21{req_imm_i[11]}});
  assign fits_13 = (req_imm_i[31:12] == {20{req_imm_i[12]}});
  assign fits_21 = (req_imm_i[31:20] == {12{req_imm_i[20]}});
  assign li_sum  = req_imm_i + 32'h0000_0800;
  assign rd      = req_base_i[11:7];

  always_comb begin
    enc_instr   = req_base_i;
    enc_err     = 1'b0;
    enc_two     = 1'b0;
    enc_pending = 32'd0;
    case (req_fmt_i)
      3'd0: begin
        if (fits_12) enc_instr = {req_imm_i[11:0], req_base_i[19:0]};
        else begin
          enc_instr = {12'd0, req_base_i[19:0]};
          enc_err   = 1'b1;
        end
      end
      3'd1: begin
        if (fits_12)
          enc_instr = {req_imm_i[11:5], req_base_i[24:12], req_imm_i[4:0], req_base_i[6:0]};
        else begin
          enc_instr = {7'd0, req_base_i[24:12], 5'd0, req_base_i[6:0]};
          enc_err   = 1'b1;
        end
      end
      3'd2: begin
        if (fits_13 && !req_imm_i[0])
          enc_instr = {req_imm_i[12], req_imm_i[10:5], req_base_i[24:12],
                       req_imm_i[4:1], req_imm_i[11], req_base_i[6:0]};
        else begin
          enc_instr = {7'd0, req_base_i[24:12], 5'd0, req_base_i[6:0]};
          enc_err   = 1'b1;
        end
      end
      3'd3: begin
        if (req_imm_i[11:0] == 12'd0) enc_instr = {req_imm_i[31:12], req_base_i[11:0]};
        else begin
          enc_instr = {20'd0, req_base_i[11:0]};
          enc_err   = 1'b1;
        end
      end
      3'd4: begin
        if (fits_21 && !req_imm_i[0])
          enc_instr = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11],
                       req_imm_i[19:12], req_base_i[11:0]};
        else begin
          enc_instr = {20'd0, req_base_i[11:0]};
          enc_err   = 1'b1;
        end
      end
      3'd5: begin
        if (fits_12) enc_instr = {req_imm_i[11:0], 5'd0, 3'b000, rd, OP_IMM};
        else begin
          // Rounding by 0x800 compensates for the sign of the trailing ADDI.
          enc_instr   = {li_sum[31:12], rd, OP_LUI};
          enc_two     = (req_imm_i[11:0] != 12'd0);
          enc_pending = {req_imm_i[11:0], rd, 3'b000, rd, OP_IMM};
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && enc_two) state_next = LI_LO;
      LI_LO:   if (out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_instr_o <= 32'd0;
      out_err_o   <= 1'b0;
      pending     <= 32'd0;
    end else if (state == LI_LO) begin
      // out_valid_o is always high here; swap in the ADDI once the LUI leaves.
      if (out_ready_i) begin
        out_instr_o <= pending;
        out_err_o   <= 1'b0;
      end
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_instr_o <= enc_instr;
      out_err_o   <= enc_err;
      if (enc_two) pending <= enc_pending;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Self-checking bench: directed scenarios plus random requests against an arithmetic reference model,
// with a round-trip decode of every good word.
module tb_instr_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [31:0] req_base;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  instr_imm_encoder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_fmt_i   (req_fmt),
    .req_base_i  (req_base),
    .req_imm_i   (req_imm),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_instr_o (out_instr),
    .out_err_o   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: immediate placement by shifts and masks, range by signed arithmetic.
  task automatic ref_model(input logic [2:0] fmt, input logic [31:0] base, input logic [31:0] imm,
                           output int n, output logic [31:0] w0, output logic [31:0] w1,
                           output logic err);
    int signed   si;
    logic [31:0] mask, field, rdv, hi, lo;
    logic        ok;
    si = $signed(imm);
    n = 1; w1 = 32'd0; err = 1'b0; mask = 32'd0; field = 32'd0; ok = 1'b1;
    rdv = (base >> 7) & 32'h1F;
    case (fmt)
      3'd0: begin
        mask = 32'hFFF0_0000; ok = (si >= -2048 && si <= 2047);
        field = (imm & 32'hFFF) << 20;
      end
      3'd1: begin
        mask = 32'hFE00_0F80; ok = (si >= -2048 && si <= 2047);
        field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      3'd2: begin
        mask = 32'hFE00_0F80; ok = (si >= -4096 && si <= 4094 && (imm & 1) == 0);
        field = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
              | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
      end
      3'd3: begin
        mask = 32'hFFFF_F000; ok = ((imm & 32'hFFF) == 0);
        field = imm & 32'hFFFF_F000;
      end
      3'd4: begin
        mask = 32'hFFFF_F000; ok = (si >= -1048576 && si <= 1048574 && (imm & 1) == 0);
        field = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
      end
      default: ;
    endcase
    if (fmt <= 3'd4) begin
      err = !ok;
      w0  = ok ? ((base & ~mask) | field) : (base & ~mask);
    end else if (fmt == 3'd5) begin
      lo = imm & 32'hFFF;
      if (si >= -2048 && si <= 2047) w0 = (lo << 20) | (rdv << 7) | 32'h13;
      else begin
        hi = (imm + 32'h800) >> 12;
        w0 = (hi << 12) | (rdv << 7) | 32'h37;
        if (lo != 0) begin
          n  = 2;
          w1 = (lo << 20) | (rdv << 15) | (rdv << 7) | 32'h13;
        end
      end
    end else begin
      err = 1'b1;
      w0  = base;
    end
  endtask

  // The core's immediate extraction, used to confirm the round trip.
  function automatic logic [31:0] extract(input logic [2:0] fmt, input logic [31:0] w);
    case (fmt)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {w[31:12], 12'd0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  // Architectural effect of an LUI/ADDI word on register rd.
  function automatic logic [31:0] execute(input logic [31:0] w, input logic [31:0] acc);
    if (w[6:0] == 7'b0110111) return {w[31:12], 12'd0};
    if (w[19:15] == 5'd0) return {{20{w[31]}}, w[31:20]};
    return acc + {{20{w[31]}}, w[31:20]};
  endfunction

  task automatic send(input string tag, input logic [2:0] fmt, input logic [31:0] base,
                      input logic [31:0] imm, output logic [31:0] o0, output logic [31:0] o1);
    int          n;
    logic [31:0] w0, w1, arch;
    logic        err;
    ref_model(fmt, base, imm, n, w0, w1, err);
    o1 = 32'd0;
    @(negedge clk);
    req_valid = 1'b1; req_fmt = fmt; req_base = base; req_imm = imm;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    o0 = out_instr;
    check({tag, " valid0"}, {31'd0, out_valid}, 32'd1);
    check({tag, " word0"}, out_instr, w0);
    check({tag, " err0"}, {31'd0, out_err}, {31'd0, err});
    arch = execute(out_instr, 32'd0);
    if (n == 2) begin
      check({tag, " ready_low"}, {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      o1 = out_instr;
      check({tag, " valid1"}, {31'd0, out_valid}, 32'd1);
      check({tag, " word1"}, out_instr, w1);
      check({tag, " err1"}, {31'd0, out_err}, 32'd0);
      arch = execute(out_instr, arch);
    end
    if (fmt == 3'd5)      check({tag, " li_result"}, arch, imm);
    else if (fmt <= 3'd4 && !err) check({tag, " roundtrip"}, extract(fmt, o0), imm);
    $display("txn %s fmt=%0d base=%h imm=%h -> %h %h err=%0b", tag, fmt, base, imm, o0, o1, out_err);
  endtask

  initial begin
    logic [31:0] a, b, stall_word, w0, w1;
    logic        e;
    int          n;
    int signed   v;
    logic [2:0]  f;

    rst = 1'b1; req_valid = 1'b0; req_fmt = 3'd0; req_base = 32'd0; req_imm = 32'd0;
    out_ready = 1'b1;
    #12;
    check("rst valid", {31'd0, out_valid}, 32'd0);
    check("rst instr", out_instr, 32'd0);
    check("rst err", {31'd0, out_err}, 32'd0);
    @(negedge clk); rst = 1'b0;
    check("rst ready", {31'd0, req_ready}, 32'd1);

    send("itype", 3'd0, 32'h0000_0293, 32'hFFFF_FFFF, a, b);
    check("itype lit", a, 32'hFFF0_0293);
    send("btype8", 3'd2, 32'h0020_8063, 32'd8, a, b);
    check("btype8 lit", a, 32'h0020_8463);
    send("btype7", 3'd2, 32'h0020_8063, 32'd7, a, b);
    check("btype7 lit", a, 32'h0020_8063);
    check("btype7 err", {31'd0, out_err}, 32'd1);
    send("btype4096", 3'd2, 32'h0020_8063, 32'd4096, a, b);
    check("btype4096 err", {31'd0, out_err}, 32'd1);
    send("li2", 3'd5, 32'h0000_0500, 32'h1234_5FFF, a, b);
    check("li2 lui", a, 32'h1234_6537);
    check("li2 addi", b, 32'hFFF5_0513);
    send("li_lui", 3'd5, 32'h0000_0500, 32'h0000_1000, a, b);
    check("li_lui lit", a, 32'h0000_1537);
    @(negedge clk);
    check("li_lui no2nd", {31'd0, out_valid}, 32'd0);
    send("li_addi", 3'd5, 32'h0000_0500, 32'hFFFF_FFEC, a, b);
    check("li_addi lit", a, 32'hFEC0_0513);
    @(negedge clk);
    check("li_addi no2nd", {31'd0, out_valid}, 32'd0);
    send("rsvd", 3'd6, 32'hDEAD_BEEF, 32'd5, a, b);
    check("rsvd err", {31'd0, out_err}, 32'd1);

    // Backpressure: hold a word for three cycles, then stream four requests.
    @(negedge clk);
    out_ready = 1'b0;
    req_valid = 1'b1; req_fmt = 3'd0; req_base = 32'h0000_0013; req_imm = 32'd5;
    ref_model(3'd0, 32'h0000_0013, 32'd5, n, stall_word, w1, e);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp stable", out_instr, stall_word);
      check("bp valid", {31'd0, out_valid}, 32'd1);
      check("bp ready_low", {31'd0, req_ready}, 32'd0);
      $display("txn bp cycle %0d instr=%h ready=%0b", c, out_instr, req_ready);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin
        ref_model(3'd0, 32'h0000_0093, c, n, w0, w1, e);
        check("stream valid", {31'd0, out_valid}, 32'd1);
        check("stream word", out_instr, w0);
        $display("txn stream %0d instr=%h", c, out_instr);
      end
      if (c < 4) begin
        req_valid = 1'b1; req_fmt = 3'd0; req_base = 32'h0000_0093; req_imm = c + 1;
      end else req_valid = 1'b0;
      @(negedge clk);
    end

    // Reset while the LUI waits in LI_LO; a request during reset must be ignored.
    out_ready = 1'b0;
    req_valid = 1'b1; req_fmt = 3'd5; req_base = 32'h0000_0500; req_imm = 32'h1234_5FFF;
    @(negedge clk);
    req_valid = 1'b0;
    check("lilo lui", out_instr, 32'h1234_6537);
    check("lilo ready_low", {31'd0, req_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async valid", {31'd0, out_valid}, 32'd0);
    check("async instr", out_instr, 32'd0);
    $display("txn reset in LI_LO valid=%0b instr=%h", out_valid, out_instr);
    req_valid = 1'b1; req_fmt = 3'd0; req_base = 32'h0000_0013; req_imm = 32'd1;
    @(negedge clk);
    req_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("post_rst ready", {31'd0, req_ready}, 32'd1);
      check("post_rst no_addi", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 8191) - 4096;
        1:       v = $urandom_range(0, 2097151) - 1048576;
        2:       v = $urandom;
        default: v = $urandom & 32'hFFFF_F000;
      endcase
      if ($urandom_range(0, 1) == 1) v = v & ~1;
      f = 3'($urandom_range(0, 7));
      send($sformatf("rnd%0d", i), f, $urandom, v, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
